// File: rtl/counter_b4_core.sv
// 4-bit multi-mode counter: +STEP, -1, +1 or parallel load, with registered
// wrap (rco) and load-acknowledge flags.
module counter_b4_core #(
    parameter int unsigned NBITS = 4,
    parameter int unsigned STEP  = 3
) (
    input  logic             b4_clk,
    input  logic             b4_reset,
    input  logic             b4_enable,
    input  logic [1:0]       b4_mode,
    input  logic [NBITS-1:0] b4_D,
    output logic [NBITS-1:0] b4_Q,
    output logic             b4_rco,
    output logic             b4_load
);

    typedef enum logic [1:0] {
        MODE_STEP = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_UP   = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    localparam logic [NBITS:0] STEP_W = (NBITS+1)'(STEP);
    localparam logic [NBITS:0] ONE_W  = (NBITS+1)'(1);

    logic [NBITS-1:0] q_q, q_d;
    logic             rco_q, rco_d;
    logic             load_q, load_d;
    logic [NBITS:0]   sum;

    // The extra top bit of the widened sum is the carry out used for rco.
    always_comb begin
        q_d    = q_q;
        rco_d  = 1'b0;
        load_d = 1'b0;
        sum    = '0;
        if (b4_enable) begin
            unique case (mode_e'(b4_mode))
                MODE_STEP: begin
                    sum   = {1'b0, q_q} + STEP_W;
                    q_d   = sum[NBITS-1:0];
                    rco_d = sum[NBITS];
                end
                MODE_DOWN: begin
                    q_d   = q_q - 1'b1;
                    rco_d = (q_q == '0);
                end
                MODE_UP: begin
                    sum   = {1'b0, q_q} + ONE_W;
                    q_d   = sum[NBITS-1:0];
                    rco_d = sum[NBITS];
                end
                MODE_LOAD: begin
                    q_d    = b4_D;
                    load_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge b4_clk or negedge b4_reset) begin
        if (!b4_reset) begin
            q_q    <= '0;
            rco_q  <= 1'b0;
            load_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            rco_q  <= rco_d;
            load_q <= load_d;
        end
    end

    assign b4_Q    = q_q;
    assign b4_rco  = rco_q;
    assign b4_load = load_q;

endmodule
